number_sprite: RTL and testbench

- Multi-digit decimal number sprite for the HUD draw engine.
- Accepts a binary value and converts it to BCD with a sequential double-dabble engine, started by a `Load` pulse.
- Holds the converted digits in a display register that stays stable for the whole frame.
- Outputs a registered per-pixel `IsDigit` mask for a row of `DIGITS` glyphs at a fixed screen position, using the shared 8×16 digit font ROM.
- Replaces per-digit sprite instances for HP, gold, attack and other counters.

---
 rtl/number_sprite_pkg.sv | 27 ++
 rtl/DigitFontRom.sv | 34 +++
 rtl/number_sprite_bin2bcd_seq.sv | 103 ++++++++++
 rtl/number_sprite.sv | 138 +++++++++++++
 tb/tb_number_sprite.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/number_sprite_pkg.sv
// number_sprite_pkg: shared types and constants for the decimal number sprite.
//   - conv_state_e : state encoding of the sequential binary-to-BCD converter
//   - GLYPH_W/GLYPH_H : glyph cell size of the shared digit font (pixels)
//   - ROM_AW : address width of the digit font ROM
//   - pow10(n) : 10**n as a constant function, used for the saturation limit
package number_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } conv_state_e;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW  = 8;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/DigitFontRom.sv
// DigitFontRom: shared 8x16 digit font, combinational read.
//   addr [7:0] : {glyph, row}; glyph 0 is blank, glyphs 1..10 are '0'..'9'
//   data [7:0] : row bitmap, bit 7 is the leftmost pixel
// Addresses above 175 read as zero.
module DigitFontRom (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    logic [127:0] glyph;
    logic [6:0]   sel;

    always_comb begin
        glyph = '0;
        case (addr[7:4])
            4'd1:    glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd2:    glyph = 128'h00001838781818181818187E00000000;
            4'd3:    glyph = 128'h00007CC6060C183060C0C6FE00000000;
            4'd4:    glyph = 128'h00007CC606063C060606C67C00000000;
            4'd5:    glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd6:    glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd7:    glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd8:    glyph = 128'h0000FEC606060C183030303000000000;
            4'd9:    glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd10:   glyph = 128'h00007CC6C6C67E0606060C7800000000;
            default: glyph = '0;
        endcase
    end

    // Row 0 sits in the top byte of the glyph word.
    assign sel  = {~addr[3:0], 3'b000};
    assign data = glyph[sel +: 8];

endmodule

// File: rtl/number_sprite_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : capture value_i and start (honoured in IDLE only)
//   value_i        : unsigned binary input
//   busy_o         : registered, high one cycle after the FSM leaves IDLE
//                    until one cycle after it returns
//   done_o         : high during COMMIT, result valid
//   sat_o          : captured value exceeds DIGITS decimal digits
//   bcd_o          : BCD result, most significant nibble on top
//
// state   | meaning
// IDLE    | waiting for start_i
// CONVERT | one add-3/shift step per cycle, VALUE_W cycles
// COMMIT  | result valid for one cycle
module bin2bcd_seq
    import number_sprite_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [VALUE_W-1:0]    value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sat_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [31:0]      SAT_LIM  = pow10(DIGITS) - 32'd1;

    conv_state_e         state_q, state_d;
    logic [VALUE_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                busy_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    sat_d   = (32'(value_i) > SAT_LIM);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    assign busy_o = busy_q;
    assign done_o = (state_q == COMMIT);
    assign sat_o  = sat_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/number_sprite.sv
// number_sprite: row of DIGITS decimal glyphs at (COOR_X, COOR_Y).
//   Clk, Reset_n   : pixel clock, async active-low reset
//   DrawX, DrawY   : current pixel
//   Value, Load    : binary value and capture request
//   Busy           : conversion in progress, Load ignored
//   IsDigit        : registered glyph mask for the previous cycle's pixel
// Build option NUMBER_SPRITE_LZB_EN: leading-zero blanking (rightmost digit
// always drawn). Without it all digits are drawn, zero padded.
module number_sprite
    import number_sprite_pkg::*;
#(
    parameter logic [9:0] COOR_X  = 10'd90,
    parameter logic [9:0] COOR_Y  = 10'd8,
    parameter int         DIGITS  = 4,
    parameter int         VALUE_W = 14
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [VALUE_W-1:0] Value,
    input  logic               Load,
    output logic               Busy,
    output logic               IsDigit
);

    localparam int BCD_W = 4 * DIGITS;
    localparam logic [9:0] BOX_W = 10'(GLYPH_W * DIGITS);
    localparam logic [9:0] BOX_H = 10'(GLYPH_H);

    logic              conv_done;
    logic              conv_sat;
    logic [BCD_W-1:0]  conv_bcd;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic [DIGITS-1:0] blank;
    logic              is_digit_q, is_digit_d;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .start_i (Load),
        .value_i (Value),
        .busy_o  (Busy),
        .done_o  (conv_done),
        .sat_o   (conv_sat),
        .bcd_o   (conv_bcd)
    );

    assign disp_d = conv_sat ? {DIGITS{4'd9}} : conv_bcd;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            disp_q <= '0;
        end else if (conv_done) begin
            disp_q <= disp_d;
        end
    end

`ifdef NUMBER_SPRITE_LZB_EN
    // Reset shows a single '0' in the rightmost digit.
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} >> 1;

    logic [DIGITS-1:0] blank_q, blank_d;

    always_comb begin
        logic lead;
        lead    = 1'b1;
        blank_d = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            lead       = lead & (disp_d[4*(DIGITS-1-i) +: 4] == 4'd0);
            blank_d[i] = lead;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_q <= BLANK_RST;
        end else if (conv_done) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    // Underflow wraps to a large value, which fails the box compare.
    logic [9:0]        pos_x, pos_y;
    logic              in_box;
    logic [6:0]        digit_idx;
    logic [2:0]        col;
    logic [3:0]        nib;
    logic              blank_sel;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    assign pos_x     = DrawX - COOR_X;
    assign pos_y     = DrawY - COOR_Y;
    assign in_box    = (pos_x < BOX_W) && (pos_y < BOX_H);
    assign digit_idx = pos_x[9:3];
    assign col       = pos_x[2:0];

    // Digit 0 is leftmost and carries the most significant nibble.
    always_comb begin
        nib       = 4'd0;
        blank_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == 7'(i)) begin
                nib       = disp_q[4*(DIGITS-1-i) +: 4];
                blank_sel = blank[i];
            end
        end
    end

    assign rom_addr = in_box ? {nib + 4'd1, pos_y[3:0]} : '0;

    DigitFontRom u_font (
        .addr (rom_addr),
        .data (rom_data)
    );

    assign is_digit_d = in_box & ~blank_sel & rom_data[3'd7 - col];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_digit_q <= 1'b0;
        end else begin
            is_digit_q <= is_digit_d;
        end
    end

    assign IsDigit = is_digit_q;

endmodule

// File: tb/tb_number_sprite.sv
// tb_number_sprite: randomized self-checking bench for number_sprite.
// The reference keeps the displayed number as an integer and derives each
// pixel from decimal arithmetic and a golden copy of the 8x16 digit font.
module tb_number_sprite;

    localparam logic [9:0] CX = 10'd90;
    localparam logic [9:0] CY = 10'd8;
    localparam int ND = 4;
    localparam int VW = 14;
`ifdef NUMBER_SPRITE_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic [VW-1:0] Value = '0;
    logic          Load = 1'b0;
    logic          Busy;
    logic          IsDigit;

    int n_checks = 0;
    int n_errors = 0;
    int shown = 0;
    logic [127:0] font [10];

    number_sprite #(
        .COOR_X  (CX),
        .COOR_Y  (CY),
        .DIGITS  (ND),
        .VALUE_W (VW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .Value   (Value),
        .Load    (Load),
        .Busy    (Busy),
        .IsDigit (IsDigit)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic bit exp_pix(input int x, input int y);
        int px, py, d, c, dv;
        logic [127:0] f;
        logic [7:0] rb;
        px = x - int'(CX);
        py = y - int'(CY);
        if (px < 0 || px >= 8 * ND || py < 0 || py >= 16) return 1'b0;
        d  = px / 8;
        c  = px % 8;
        dv = (shown / p10(ND - 1 - d)) % 10;
        if (LZB && d < ND - 1 && shown < p10(ND - 1 - d)) return 1'b0;
        f  = font[dv];
        rb = f[127 - 8*py -: 8];
        return rb[7 - c];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, output bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        b = IsDigit;
    endtask

    task automatic probe(input string tag, input int x, input int y);
        bit b;
        pix(x, y, b);
        check(tag, b, exp_pix(x, y));
    endtask

    // One check per row: columns COOR_X-1 .. COOR_X+32.
    task automatic scan(input string tag);
        logic [33:0] obs, exp;
        bit b;
        for (int r = -1; r <= 16; r++) begin
            obs = '0;
            exp = '0;
            for (int cc = -1; cc <= 32; cc++) begin
                pix(int'(CX) + cc, int'(CY) + r, b);
                obs[cc + 1] = b;
                exp[cc + 1] = exp_pix(int'(CX) + cc, int'(CY) + r);
            end
            check($sformatf("%s row%0d", tag, r), obs, exp);
        end
    endtask

    task automatic count_busy(input int start, output int n);
        n = start;
        for (int k = 0; k < 200; k++) begin
            step();
            if (Busy) n++;
            else break;
        end
    endtask

    task automatic set_shown(input int v);
        shown = (v > p10(ND) - 1) ? p10(ND) - 1 : v;
    endtask

    task automatic load_val(input int v, input string tag);
        int n;
        Value = VW'(v);
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        check({tag, " busy_edge0"}, Busy, 1'b0);
        count_busy(0, n);
        check({tag, " busy_len"}, n, VW + 1);
        set_shown(v);
    endtask

    initial begin
        int n;
        int v;
        bit b;
        font[0] = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
        font[1] = 128'h00001838781818181818187E00000000;
        font[2] = 128'h00007CC6060C183060C0C6FE00000000;
        font[3] = 128'h00007CC606063C060606C67C00000000;
        font[4] = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
        font[5] = 128'h0000FEC0C0C0FC060606C67C00000000;
        font[6] = 128'h00003860C0C0FCC6C6C6C67C00000000;
        font[7] = 128'h0000FEC606060C183030303000000000;
        font[8] = 128'h00007CC6C6C67CC6C6C6C67C00000000;
        font[9] = 128'h00007CC6C6C67E0606060C7800000000;

        // Held in reset: mask and busy low regardless of pixel.
        Reset_n = 1'b0;
        Value = VW'(1234);
        Load = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pix(int'(CX) + 2 + 5 * k, int'(CY) + 4 + k, b);
            check("rst isdigit", b, 1'b0);
            check("rst busy", Busy, 1'b0);
        end
        Load = 1'b0;
        Reset_n = 1'b1;
        step();
        shown = 0;
        scan("reset");

        load_val(1234, "v1234");
        scan("v1234");

        probe("left_edge", int'(CX) - 1, int'(CY) + 5);
        probe("right_edge", int'(CX) + 32, int'(CY) + 5);
        probe("bottom_edge", int'(CX) + 10, int'(CY) + 16);
        probe("last_pixel", int'(CX) + 31, int'(CY) + 15);
        probe("first_pixel", int'(CX) + 1, int'(CY) + 4);

        load_val(12345, "sat");
        scan("sat");

        // Load during CONVERT is dropped.
        load_val(1234, "pre_drop");
        Value = VW'(1234);
        Load = 1'b1;
        step();
        Load = 1'b0;
        n = 0;
        repeat (2) begin
            step();
            if (Busy) n++;
        end
        Value = VW'(7);
        Load = 1'b1;
        step();
        if (Busy) n++;
        Load = 1'b0;
        count_busy(n, n);
        check("drop busy_len", n, VW + 1);
        scan("drop");
        load_val(7, "v7");
        scan("v7");

        // Reset in CONVERT cycle 5 aborts the conversion.
        Value = VW'(999);
        Load = 1'b1;
        step();
        Load = 1'b0;
        repeat (5) step();
        Reset_n = 1'b0;
        #1;
        check("midrst busy", Busy, 1'b0);
        check("midrst isdigit", IsDigit, 1'b0);
        step();
        Reset_n = 1'b1;
        shown = 0;
        step();
        check("postrst busy", Busy, 1'b0);
        scan("postrst");
        load_val(999, "v999");
        scan("v999");

        // Load held high re-triggers after COMMIT.
        Value = VW'(42);
        Load = 1'b1;
        step();
        count_busy(0, n);
        check("hold busy_len", n, VW + 1);
        step();
        check("hold retrigger", Busy, 1'b1);
        Load = 1'b0;
        count_busy(1, n);
        check("hold busy_len2", n, VW + 1);
        set_shown(42);
        scan("v42");

        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) v = int'($urandom_range(0, p10(ND) - 1));
            else v = int'($urandom_range(0, (1 << VW) - 1));
            load_val(v, $sformatf("rnd%0d", k));
            scan($sformatf("rnd%0d v=%0d", k, v));
            for (int j = 0; j < 40; j++) begin
                probe("rnd_near", int'(CX) - 4 + int'($urandom_range(0, 40)),
                      int'(CY) - 2 + int'($urandom_range(0, 20)));
            end
            for (int j = 0; j < 10; j++) begin
                probe("rnd_far", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
